// File: rtl/cacheline_arbiter.sv
// Round-robin arbiter sharing one line-granular memory port between the I-cache and D-cache.
// One line transaction is in flight at a time; responses are routed only to the granted side.
module cacheline_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic              protocol_err
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    state_t state_reg, state_next;
    logic   last_d_reg;
    logic   err_reg;
    logic   i_pend, d_pend;
    logic   err_set;

    assign i_pend = i_read | i_write;
    assign d_pend = d_read | d_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // The owner's own request during its resp cycle is ignored, so a hand-off
    // only ever looks at the other requester.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (i_pend && (!d_pend || last_d_reg)) state_next = SERVE_I;
                else if (d_pend)                       state_next = SERVE_D;
            end
            SERVE_I: if (mem_resp) state_next = d_pend ? SERVE_D : IDLE;
            SERVE_D: if (mem_resp) state_next = i_pend ? SERVE_I : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_wdata = '0;
        i_rdata   = '0;
        i_resp    = 1'b0;
        d_rdata   = '0;
        d_resp    = 1'b0;
        case (state_reg)
            SERVE_I: begin
                mem_addr  = i_addr;
                mem_read  = i_read;
                mem_write = i_write;
                mem_wdata = i_wdata;
                i_rdata   = mem_rdata;
                i_resp    = mem_resp;
            end
            SERVE_D: begin
                mem_addr  = d_addr;
                mem_read  = d_read;
                mem_write = d_write;
                mem_wdata = d_wdata;
                d_rdata   = mem_rdata;
                d_resp    = mem_resp;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d_reg <= 1'b1;
        end else if (state_next == SERVE_D) begin
            last_d_reg <= 1'b1;
        end else if (state_next == SERVE_I) begin
            last_d_reg <= 1'b0;
        end
    end

    // Illegal events: read+write on a granted/being-granted side, a response
    // with nobody granted, or the owner withdrawing before its response.
    always_comb begin
        err_set = 1'b0;
        if ((state_reg == SERVE_I || state_next == SERVE_I) && i_read && i_write) err_set = 1'b1;
        if ((state_reg == SERVE_D || state_next == SERVE_D) && d_read && d_write) err_set = 1'b1;
        if (state_reg == IDLE && mem_resp)                                         err_set = 1'b1;
        if (state_reg == SERVE_I && !i_pend && !mem_resp)                          err_set = 1'b1;
        if (state_reg == SERVE_D && !d_pend && !mem_resp)                          err_set = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (err_set) begin
            err_reg <= 1'b1;
        end
    end

    assign protocol_err = err_reg;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Bench for cacheline_arbiter: a vector table, hand-written corner sequences and a
// randomized run against a round-robin ownership model.
module tb_cacheline_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    localparam logic [31:0]  IA  = 32'h0000_1A40;
    localparam logic [31:0]  DA  = 32'h0000_2B80;
    localparam logic [255:0] IWD = {8{32'h1111_2222}};
    localparam logic [255:0] DWD = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] PAT = {32{8'hA5}};

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] i_addr, d_addr, mem_addr;
    logic              i_read, i_write, d_read, d_write;
    logic [LINE_W-1:0] i_wdata, d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
    logic              i_resp, d_resp, mem_read, mem_write, mem_resp, protocol_err;

    int checks = 0;
    int errors = 0;

    cacheline_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read(i_read), .i_write(i_write), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    // Field order: ir iw dr dw mr | emr emw eir edr | sel(0 none,1 I,2 D) | err
    typedef struct packed {
        logic       ir, iw, dr, dw, mr;
        logic       emr, emw, eir, edr;
        logic [1:0] sel;
        logic       eerr;
    } vec_t;

    vec_t tbl[17];

    // Reference model state: owner -1 none, 0 I-cache, 1 D-cache
    int             owner, last;
    logic           merr;
    logic           rq_rd[2], rq_wr[2];
    logic [31:0]    rq_addr[2];
    logic [255:0]   rq_wd[2];
    int             wait_cnt, target;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_cycle(input string tag, input logic emr, input logic emw,
                                input logic eir, input logic edr, input int sel, input logic eerr,
                                input logic [31:0] ia, input logic [31:0] da,
                                input logic [255:0] iwd, input logic [255:0] dwd,
                                input logic [255:0] rd);
        logic [31:0]  ea;
        logic [255:0] ew;
        ea = (sel == 1) ? ia  : (sel == 2) ? da  : 32'h0;
        ew = (sel == 1) ? iwd : (sel == 2) ? dwd : 256'h0;
        chk({tag, ".mem_read"},  256'(mem_read),  256'(emr));
        chk({tag, ".mem_write"}, 256'(mem_write), 256'(emw));
        chk({tag, ".mem_addr"},  256'(mem_addr),  256'(ea));
        chk({tag, ".mem_wdata"}, mem_wdata, ew);
        chk({tag, ".i_resp"},    256'(i_resp),    256'(eir));
        chk({tag, ".d_resp"},    256'(d_resp),    256'(edr));
        chk({tag, ".i_rdata"},   i_rdata, (sel == 1) ? rd : 256'h0);
        chk({tag, ".d_rdata"},   d_rdata, (sel == 2) ? rd : 256'h0);
        chk({tag, ".protocol_err"}, 256'(protocol_err), 256'(eerr));
    endtask

    task automatic clear_inputs();
        i_read = 0; i_write = 0; d_read = 0; d_write = 0; mem_resp = 0;
        i_addr = IA; d_addr = DA; i_wdata = IWD; d_wdata = DWD; mem_rdata = PAT;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1;
        @(negedge clk);
        rst = 0;
        owner = -1; last = 1; merr = 0;
    endtask

    function automatic logic pend(input int k);
        return rq_rd[k] | rq_wr[k];
    endfunction

    // Round robin: among pending requesters other than the current owner,
    // prefer the one that was not granted last.
    task automatic model_step();
        int  nxt;
        logic c0, c1;
        if (owner < 0 && mem_resp) merr = 1;
        if (owner >= 0) begin
            if (rq_rd[owner] && rq_wr[owner]) merr = 1;
            if (!pend(owner) && !mem_resp)    merr = 1;
        end
        if (owner >= 0 && !mem_resp) begin
            nxt = owner;
        end else begin
            c0 = pend(0) && owner != 0;
            c1 = pend(1) && owner != 1;
            if (c0 && c1)  nxt = (last == 1) ? 0 : 1;
            else if (c0)   nxt = 0;
            else if (c1)   nxt = 1;
            else           nxt = -1;
        end
        if (nxt >= 0 && nxt != owner && rq_rd[nxt] && rq_wr[nxt]) merr = 1;
        if (owner >= 0 && mem_resp) begin
            rq_rd[owner] = 0;
            rq_wr[owner] = 0;
            target = $urandom_range(0, 3);
        end
        if (nxt != owner) wait_cnt = 0;
        else if (owner >= 0) wait_cnt++;
        if (nxt >= 0) last = nxt;
        owner = nxt;
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        tbl[0]  = 12'b0_0_0_0_0_0_0_0_0_00_0;
        tbl[1]  = 12'b1_0_0_1_0_0_0_0_0_00_0;
        tbl[2]  = 12'b1_0_0_1_0_1_0_0_0_01_0;
        tbl[3]  = 12'b1_0_0_1_0_1_0_0_0_01_0;
        tbl[4]  = 12'b1_0_0_1_1_1_0_1_0_01_0;
        tbl[5]  = 12'b0_0_0_1_0_0_1_0_0_10_0;
        tbl[6]  = 12'b0_0_0_1_1_0_1_0_1_10_0;
        tbl[7]  = 12'b0_0_0_0_0_0_0_0_0_00_0;
        tbl[8]  = 12'b0_0_1_0_0_0_0_0_0_00_0;
        tbl[9]  = 12'b0_0_1_0_1_1_0_0_1_10_0;
        tbl[10] = 12'b1_0_1_0_0_0_0_0_0_00_0;
        tbl[11] = 12'b1_0_1_0_1_1_0_1_0_01_0;
        tbl[12] = 12'b1_0_1_0_1_1_0_0_1_10_0;
        tbl[13] = 12'b1_0_0_0_0_1_0_0_0_01_0;
        tbl[14] = 12'b1_0_0_0_1_1_0_1_0_01_0;
        tbl[15] = 12'b0_0_0_0_1_0_0_0_0_00_0;
        tbl[16] = 12'b0_0_0_0_0_0_0_0_0_00_1;

        // Reset state is checked while rst is still held
        #2;
        expect_cycle("reset", 0, 0, 0, 0, 0, 0, IA, DA, IWD, DWD, PAT);
        @(negedge clk);
        rst = 0;

        for (int n = 0; n < 17; n++) begin
            @(negedge clk);
            i_read = tbl[n].ir; i_write = tbl[n].iw;
            d_read = tbl[n].dr; d_write = tbl[n].dw;
            mem_resp = tbl[n].mr;
            #1;
            expect_cycle($sformatf("vec%0d", n), tbl[n].emr, tbl[n].emw, tbl[n].eir, tbl[n].edr,
                         int'(tbl[n].sel), tbl[n].eerr, IA, DA, IWD, DWD, PAT);
        end

        // Read and write together while D owns the port
        do_reset();
        d_read = 1;
        @(negedge clk);
        d_write = 1;
        #1 chk("rw_both.err_not_yet", 256'(protocol_err), 256'(0));
        @(negedge clk);
        #1 chk("rw_both.err_set", 256'(protocol_err), 256'(1));
        d_read = 1; d_write = 0; mem_resp = 1;
        @(negedge clk);
        d_read = 0; mem_resp = 0;
        @(negedge clk);
        #1 chk("rw_both.err_sticky", 256'(protocol_err), 256'(1));

        // Owner withdraws before its response: port follows, grant is kept
        do_reset();
        i_read = 1;
        @(negedge clk);
        #1 chk("drop.mem_read_up", 256'(mem_read), 256'(1));
        i_read = 0;
        #1 chk("drop.mem_read_follows", 256'(mem_read), 256'(0));
        @(negedge clk);
        mem_resp = 1;
        #1 chk("drop.err", 256'(protocol_err), 256'(1));
        chk("drop.still_granted_resp", 256'(i_resp), 256'(1));
        @(negedge clk);
        mem_resp = 0;

        // Asynchronous reset in the middle of a D transaction
        do_reset();
        d_read = 1; d_addr = 32'h0000_7700;
        @(negedge clk);
        #1 chk("areset.d_granted", 256'(mem_read), 256'(1));
        #1 rst = 1;
        #1 chk("areset.mem_read_drop", 256'(mem_read), 256'(0));
        chk("areset.mem_addr_zero", 256'(mem_addr), 256'(0));
        @(negedge clk);
        i_read = 1;
        rst = 0;
        @(negedge clk);
        #1 chk("areset.i_first_addr", 256'(mem_addr), 256'(IA));
        chk("areset.i_first_read", 256'(mem_read), 256'(1));
        mem_resp = 1;
        #1 chk("areset.i_resp", 256'(i_resp), 256'(1));
        @(negedge clk);
        i_read = 0; mem_resp = 0;
        #1 chk("areset.d_next_addr", 256'(mem_addr), 256'(32'h0000_7700));
        chk("areset.no_err", 256'(protocol_err), 256'(0));

        // Randomized legal traffic against the ownership model
        do_reset();
        for (int k = 0; k < 2; k++) begin
            rq_rd[k] = 0; rq_wr[k] = 0; rq_addr[k] = 0; rq_wd[k] = 0;
        end
        wait_cnt = 0;
        target = $urandom_range(0, 3);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!pend(k) && $urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 1) == 1) rq_wr[k] = 1;
                    else                           rq_rd[k] = 1;
                    rq_addr[k] = $urandom & 32'hFFFF_FFE0;
                    rq_wd[k]   = {8{$urandom}};
                end
            end
            i_read = rq_rd[0]; i_write = rq_wr[0]; i_addr = rq_addr[0]; i_wdata = rq_wd[0];
            d_read = rq_rd[1]; d_write = rq_wr[1]; d_addr = rq_addr[1]; d_wdata = rq_wd[1];
            mem_resp  = (owner >= 0) && (wait_cnt >= target);
            mem_rdata = {8{$urandom}};
            #1;
            expect_cycle($sformatf("rand%0d", cyc),
                         (owner >= 0) ? rq_rd[owner] : 1'b0,
                         (owner >= 0) ? rq_wr[owner] : 1'b0,
                         (owner == 0) && mem_resp, (owner == 1) && mem_resp,
                         owner + 1, merr, rq_addr[0], rq_addr[1], rq_wd[0], rq_wd[1], mem_rdata);
            @(posedge clk);
            model_step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
